zone_time_formatter: RTL

//  Multi-zone local-time engine for the world clock. On a start pulse it latches the

---
 rtl/zone_time_formatter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/zone_time_formatter.sv
// Multi-zone local-time engine: latches a reference time and NUM_ZONES signed minute
// offsets on start, then emits one zone's display-format local time per clock.
module zone_time_formatter #(
  parameter int NUM_ZONES   = 4,
  parameter int OFS_W       = 12,
  parameter bit MIDNIGHT_12 = 1'b1,
  localparam int ZW         = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [4:0]                 hour24,
  input  logic [5:0]                 minute,
  input  logic                       mode_12h,
  input  logic [NUM_ZONES*OFS_W-1:0] zone_ofs,
  output logic                       busy,
  output logic                       out_valid,
  output logic [ZW-1:0]              out_zone,
  output logic [4:0]                 out_hour,
  output logic [5:0]                 out_min,
  output logic                       out_pm,
  output logic [1:0]                 out_day,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_t;

  localparam logic signed [OFS_W-1:0] OFS_MAX = OFS_W'(1439);
  localparam logic signed [OFS_W-1:0] OFS_MIN = -OFS_MAX;

  state_t                  state_q, state_d;
  logic [ZW-1:0]           idx_q, idx_d;
  logic [4:0]              hour_q;
  logic [5:0]              min_q;
  logic                    mode_q;
  logic signed [OFS_W-1:0] ofs_q [NUM_ZONES];
  logic                    accept_s, valid_d, done_d, err_d;

  logic signed [OFS_W-1:0] ofs_sel_s;
  logic signed [OFS_W:0]   ofs_x_s;
  logic signed [12:0]      ofs_c_s, t_s;
  logic [12:0]             base_s, t_adj_s;
  logic [1:0]              day_s;
  logic [4:0]              h_s, hour_disp_s;
  logic [5:0]              m_s;
  logic                    pm_s;

  // Next-state and control pulses for the IDLE/CALC scan.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    accept_s = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((hour24 <= 5'd23) && (minute <= 6'd59)) begin
            accept_s = 1'b1;
            state_d  = CALC;
            idx_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        valid_d = 1'b1;
        if (idx_q == ZW'(NUM_ZONES - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ZW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Local time of the zone currently indexed: clamp, wrap into one day, split and format.
  always_comb begin
    ofs_sel_s = ofs_q[idx_q];
    ofs_x_s   = {ofs_sel_s[OFS_W-1], ofs_sel_s};
    if (ofs_sel_s > OFS_MAX) begin
      ofs_c_s = 13'sd1439;
    end else if (ofs_sel_s < OFS_MIN) begin
      ofs_c_s = -13'sd1439;
    end else begin
      ofs_c_s = ofs_x_s[12:0];
    end
    base_s = 13'(hour_q) * 13'd60 + 13'(min_q);
    t_s    = $signed(base_s) + ofs_c_s;
    if (t_s < 13'sd0) begin
      t_adj_s = $unsigned(t_s + 13'sd1440);
      day_s   = 2'b11;
    end else if (t_s >= 13'sd1440) begin
      t_adj_s = $unsigned(t_s - 13'sd1440);
      day_s   = 2'b01;
    end else begin
      t_adj_s = $unsigned(t_s);
      day_s   = 2'b00;
    end
    h_s = 5'(t_adj_s / 13'd60);
    m_s = 6'(t_adj_s % 13'd60);
    if (!mode_q) begin
      hour_disp_s = h_s;
      pm_s        = 1'b0;
    end else if (h_s == 5'd0) begin
      hour_disp_s = MIDNIGHT_12 ? 5'd12 : 5'd0;
      pm_s        = 1'b0;
    end else if (h_s < 5'd12) begin
      hour_disp_s = h_s;
      pm_s        = 1'b0;
    end else if (h_s == 5'd12) begin
      hour_disp_s = 5'd12;
      pm_s        = 1'b1;
    end else begin
      hour_disp_s = h_s - 5'd12;
      pm_s        = 1'b1;
    end
  end

  // State, request latches and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hour_q    <= 5'd0;
      min_q     <= 6'd0;
      mode_q    <= 1'b0;
      for (int k = 0; k < NUM_ZONES; k++) ofs_q[k] <= '0;
      out_valid <= 1'b0;
      out_zone  <= '0;
      out_hour  <= 5'd0;
      out_min   <= 6'd0;
      out_pm    <= 1'b0;
      out_day   <= 2'b00;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      out_valid <= valid_d;
      done      <= done_d;
      err       <= err_d;
      if (accept_s) begin
        hour_q <= hour24;
        min_q  <= minute;
        mode_q <= mode_12h;
        for (int k = 0; k < NUM_ZONES; k++) ofs_q[k] <= zone_ofs[k*OFS_W +: OFS_W];
      end
      if (state_q == CALC) begin
        out_zone <= idx_q;
        out_hour <= hour_disp_s;
        out_min  <= m_s;
        out_pm   <= pm_s;
        out_day  <= day_s;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
